pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed per-stage F/D/E/M/W registers of the Y86-64 core.
- Carries an opaque packed payload of DATA_W bits.
- Supports stall and bubble control with a per-bit keep-on-bubble mask, generalising the existing "stat survives a bubble" rule.
- Adds a valid/ready handshake backed by a small skid FIFO, so stages can decouple, plus saturating stall and bubble event counters for profiling.
- Intended to replace every inter-stage register; payload layout is defined by each stage's packing constants.

---
 rtl/pipe_pkg.sv | 69 ++++++
 rtl/pipe_skid_fifo.sv | 61 ++++++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the parametrised pipeline stage register.
// Covers Y86-64 field encodings, E/M/W payload layouts, and per-stage bubble images and keep masks.
package pipe_pkg;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;
    localparam int STAT_W  = 3;
    localparam int ICODE_W = 4;
    localparam int REG_W   = 4;
    localparam int WORD_W  = 64;

    // E payload: stat | icode | ifun | valC | valA | valB | dstE | dstM | srcA | srcB
    localparam int E_STAT_LSB  = 0;
    localparam int E_ICODE_LSB = E_STAT_LSB + STAT_W;
    localparam int E_IFUN_LSB  = E_ICODE_LSB + ICODE_W;
    localparam int E_VALC_LSB  = E_IFUN_LSB + 4;
    localparam int E_VALA_LSB  = E_VALC_LSB + WORD_W;
    localparam int E_VALB_LSB  = E_VALA_LSB + WORD_W;
    localparam int E_DSTE_LSB  = E_VALB_LSB + WORD_W;
    localparam int E_DSTM_LSB  = E_DSTE_LSB + REG_W;
    localparam int E_SRCA_LSB  = E_DSTM_LSB + REG_W;
    localparam int E_SRCB_LSB  = E_SRCA_LSB + REG_W;
    localparam int E_DATA_W    = E_SRCB_LSB + REG_W;

    localparam logic [E_DATA_W-1:0] E_BUBBLE_VAL =
        (E_DATA_W'(INOP)  << E_ICODE_LSB) |
        (E_DATA_W'(RNONE) << E_DSTE_LSB)  |
        (E_DATA_W'(RNONE) << E_DSTM_LSB)  |
        (E_DATA_W'(RNONE) << E_SRCA_LSB)  |
        (E_DATA_W'(RNONE) << E_SRCB_LSB);
    localparam logic [E_DATA_W-1:0] E_KEEP_MASK = E_DATA_W'({STAT_W{1'b1}}) << E_STAT_LSB;

    // M payload: stat | icode | cnd | valE | valA | dstE | dstM
    localparam int M_STAT_LSB  = 0;
    localparam int M_ICODE_LSB = M_STAT_LSB + STAT_W;
    localparam int M_CND_LSB   = M_ICODE_LSB + ICODE_W;
    localparam int M_VALE_LSB  = M_CND_LSB + 1;
    localparam int M_VALA_LSB  = M_VALE_LSB + WORD_W;
    localparam int M_DSTE_LSB  = M_VALA_LSB + WORD_W;
    localparam int M_DSTM_LSB  = M_DSTE_LSB + REG_W;
    localparam int M_DATA_W    = M_DSTM_LSB + REG_W;

    localparam logic [M_DATA_W-1:0] M_BUBBLE_VAL =
        (M_DATA_W'(INOP)  << M_ICODE_LSB) |
        (M_DATA_W'(RNONE) << M_DSTE_LSB)  |
        (M_DATA_W'(RNONE) << M_DSTM_LSB);
    localparam logic [M_DATA_W-1:0] M_KEEP_MASK = M_DATA_W'({STAT_W{1'b1}}) << M_STAT_LSB;

    // W payload: stat | icode | valE | valM | dstE | dstM
    localparam int W_STAT_LSB  = 0;
    localparam int W_ICODE_LSB = W_STAT_LSB + STAT_W;
    localparam int W_VALE_LSB  = W_ICODE_LSB + ICODE_W;
    localparam int W_VALM_LSB  = W_VALE_LSB + WORD_W;
    localparam int W_DSTE_LSB  = W_VALM_LSB + WORD_W;
    localparam int W_DSTM_LSB  = W_DSTE_LSB + REG_W;
    localparam int W_DATA_W    = W_DSTM_LSB + REG_W;

    localparam logic [W_DATA_W-1:0] W_BUBBLE_VAL =
        (W_DATA_W'(INOP)  << W_ICODE_LSB) |
        (W_DATA_W'(RNONE) << W_DSTE_LSB)  |
        (W_DATA_W'(RNONE) << W_DSTM_LSB);
    localparam logic [W_DATA_W-1:0] W_KEEP_MASK = W_DATA_W'({STAT_W{1'b1}}) << W_STAT_LSB;

    // Occupancy spans the output register plus every skid entry.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_skid_fifo.sv
// Small circular skid buffer behind the stage output register.
// Clear empties it in one cycle.
module pipe_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with stall/bubble control, valid/ready handshake,
// a skid FIFO and saturating profiling counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 200,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter logic [DATA_W-1:0] KEEP_MASK  = '0,
    parameter int                SKID_DEPTH = 2,
    parameter int                CNT_W      = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DATA_W-1:0]                   in_data_i,
    input  logic                                stall_i,
    input  logic                                bubble_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DATA_W-1:0]                   out_data_o,
    output logic [occ_width(SKID_DEPTH)-1:0]    occupancy_o,
    output logic [CNT_W-1:0]                    stall_cnt_o,
    output logic [CNT_W-1:0]                    bubble_cnt_o
);

    localparam int OCC_W  = occ_width(SKID_DEPTH);
    localparam int FCNT_W = $clog2(SKID_DEPTH + 1);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              fifo_push, fifo_pop, fifo_clear;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [FCNT_W-1:0] fifo_count;
    logic              accept;
    logic              load;

    pipe_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (in_data_i),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready depends only on bubble and FIFO space, never on downstream ready or stall.
    assign in_ready_o = !bubble_i && !fifo_full;
    assign accept     = in_valid_i && in_ready_o;
    assign load       = out_ready_i || !out_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_clear   = 1'b0;
        if (bubble_i) begin
            out_data_d   = (in_data_i & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
            out_valid_d  = 1'b1;
            fifo_clear   = 1'b1;
            bubble_cnt_d = (bubble_cnt_q == '1) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
        end else if (stall_i) begin
            fifo_push   = accept;
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end else if (load) begin
            // Older skid entries drain first so ordering is preserved.
            if (!fifo_empty) begin
                out_data_d  = fifo_head;
                out_valid_d = 1'b1;
                fifo_pop    = 1'b1;
                fifo_push   = accept;
            end else if (accept) begin
                out_data_d  = in_data_i;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            fifo_push = accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= BUBBLE_VAL;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign occupancy_o  = OCC_W'(out_valid_q) + OCC_W'(fifo_count);
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int          DATA_W  = 16;
    localparam logic [15:0] BUB     = 16'h10F0;
    localparam logic [15:0] KEEP    = 16'h0007;
    localparam int          DEPTH   = 2;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        stall_i;
    logic        bubble_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic [1:0]  occupancy_o;
    logic [3:0]  stall_cnt_o;
    logic [3:0]  bubble_cnt_o;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUB),
        .KEEP_MASK  (KEEP),
        .SKID_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .stall_i      (stall_i),
        .bubble_i     (bubble_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .occupancy_o  (occupancy_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    // Reference: a visible output slot plus an ordered queue of waiting payloads.
    bit          mValid;
    logic [15:0] mData;
    logic [15:0] mFifo [$];
    int          mStall;
    int          mBubble;
    bit          mAcc;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mValid  = 1'b0;
            mData   = BUB;
            mFifo.delete();
            mStall  = 0;
            mBubble = 0;
        end else if (bubble_i) begin
            mData   = (in_data_i & KEEP) | (BUB & ~KEEP);
            mValid  = 1'b1;
            mFifo.delete();
            if (mBubble < CNT_MAX) mBubble++;
        end else begin
            mAcc = in_valid_i && (mFifo.size() < DEPTH);
            if (stall_i) begin
                if (mAcc) mFifo.push_back(in_data_i);
                if (mStall < CNT_MAX) mStall++;
            end else if (out_ready_i || !mValid) begin
                if (mFifo.size() > 0) begin
                    mData  = mFifo.pop_front();
                    mValid = 1'b1;
                    if (mAcc) mFifo.push_back(in_data_i);
                end else if (mAcc) begin
                    mData  = in_data_i;
                    mValid = 1'b1;
                end else begin
                    mValid = 1'b0;
                end
            end else if (mAcc) begin
                mFifo.push_back(in_data_i);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (checkEn) begin
            checkOutput("in_ready",   32'(in_ready_o),   32'(!bubble_i && (mFifo.size() < DEPTH)));
            checkOutput("out_valid",  32'(out_valid_o),  32'(mValid));
            checkOutput("out_data",   32'(out_data_o),   32'(mData));
            checkOutput("occupancy",  32'(occupancy_o),  32'(int'(mValid) + mFifo.size()));
            checkOutput("stall_cnt",  32'(stall_cnt_o),  32'(mStall));
            checkOutput("bubble_cnt", 32'(bubble_cnt_o), 32'(mBubble));
        end
    end

    task automatic drive(input bit r, input bit v, input logic [15:0] d,
                         input bit st, input bit bub, input bit rdy);
        rst_i       = r;
        in_valid_i  = v;
        in_data_i   = d;
        stall_i     = st;
        bubble_i    = bub;
        out_ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] d,
                                 input bit st, input bit bub, input bit rdy);
        drive(r, v, d, st, bub, rdy);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        checkEn = 1'b1;
        checkOutput("rst_valid",  32'(out_valid_o),  32'h0);
        checkOutput("rst_data",   32'(out_data_o),   32'h10F0);
        checkOutput("rst_occ",    32'(occupancy_o),  32'h0);
        checkOutput("rst_scnt",   32'(stall_cnt_o),  32'h0);

        // Bypass: one-cycle latency through an empty stage
        applyStimulus(0, 1, 16'h00A5, 0, 0, 1);
        checkOutput("byp_data",   32'(out_data_o),   32'h00A5);
        checkOutput("byp_valid",  32'(out_valid_o),  32'h1);
        checkOutput("byp_occ",    32'(occupancy_o),  32'h1);
        checkOutput("byp_ready",  32'(in_ready_o),   32'h1);

        // Stall fills the skid FIFO, third push refused
        applyStimulus(0, 1, 16'h0001, 1, 0, 0);
        applyStimulus(0, 1, 16'h0002, 1, 0, 0);
        drive(0, 1, 16'h0003, 1, 0, 0);
        #1;
        checkOutput("full_ready", 32'(in_ready_o),   32'h0);
        tick();
        checkOutput("stall_hold", 32'(out_data_o),   32'h00A5);
        checkOutput("stall_cnt3", 32'(stall_cnt_o),  32'h3);
        checkOutput("stall_occ",  32'(occupancy_o),  32'h3);
        applyStimulus(0, 1, 16'h0003, 0, 0, 1);
        checkOutput("drain1",     32'(out_data_o),   32'h0001);
        applyStimulus(0, 1, 16'h0003, 0, 0, 1);
        checkOutput("drain2",     32'(out_data_o),   32'h0002);
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkOutput("drain3",     32'(out_data_o),   32'h0003);
        checkOutput("model_d3",   32'(mData),        32'h0003);

        // Bubble flushes a filled FIFO and keeps the stat bits
        applyStimulus(0, 1, 16'h0011, 1, 0, 0);
        applyStimulus(0, 1, 16'h0022, 1, 0, 0);
        drive(0, 1, 16'h1235, 0, 1, 0);
        #1;
        checkOutput("bub_ready",  32'(in_ready_o),   32'h0);
        tick();
        checkOutput("bub_data",   32'(out_data_o),   32'h10F5);
        checkOutput("model_bub",  32'(mData),        32'h10F5);
        checkOutput("bub_occ",    32'(occupancy_o),  32'h1);
        checkOutput("bub_cnt1",   32'(bubble_cnt_o), 32'h1);

        // Bubble wins over a simultaneous stall
        applyStimulus(0, 1, 16'h1232, 1, 1, 0);
        checkOutput("bs_data",    32'(out_data_o),   32'h10F2);
        checkOutput("bs_scnt",    32'(stall_cnt_o),  32'h5);
        checkOutput("bs_bcnt",    32'(bubble_cnt_o), 32'h2);

        // Stall counter saturates
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 16'h0, 1, 0, 0);
        checkOutput("sat_scnt",   32'(stall_cnt_o),  32'hF);

        // Reset with a partially filled FIFO discards everything
        applyStimulus(0, 1, 16'h0033, 1, 0, 0);
        applyStimulus(0, 1, 16'h0044, 1, 0, 0);
        checkOutput("pre_rst_occ", 32'(occupancy_o), 32'h3);
        applyStimulus(1, 1, 16'h0055, 1, 0, 1);
        checkOutput("mid_rst_occ", 32'(occupancy_o), 32'h0);
        checkOutput("mid_rst_vld", 32'(out_valid_o), 32'h0);
        checkOutput("mid_rst_dat", 32'(out_data_o),  32'h10F0);

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          ($urandom % 10) < 7,
                          16'($urandom),
                          ($urandom % 5) == 0,
                          ($urandom % 20) == 0,
                          1'($urandom % 2));
        end

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
